// File: rtl/ama_riscv_load_pkg.sv
// rtl/ama_riscv_load_pkg.sv - load funct3 codes, FSM state encoding and decode helpers
package ama_riscv_load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_CAP, S_RESP} load_state_e;

  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_RD0  = S_RD0;
  localparam logic [2:0] ST_RD1  = S_RD1;
  localparam logic [2:0] ST_CAP  = S_CAP;
  localparam logic [2:0] ST_RESP = S_RESP;

  function automatic logic [3:0] load_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // Doubleword and unsigned-word loads only exist on RV64.
  function automatic logic load_legal(input logic [2:0] f3, input int xlen);
    if (f3 == 3'b111) return 1'b0;
    if ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU))) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/ama_riscv_load_align_unit_if.sv
// rtl/ama_riscv_load_align_unit_if.sv - load request/response handshake bundle
interface ama_riscv_load_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ama_riscv_load_extract.sv
// rtl/ama_riscv_load_extract.sv - pick size bytes at off from a two-word window and extend
module ama_riscv_load_extract #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         window,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [3:0]                size,
  input  logic                      unsigned_ld,
  output logic [XLEN-1:0]           data
);
  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   mask;
  logic              sign;

  always_comb begin
    shifted = window >> {off, 3'b000};
    raw     = shifted[XLEN-1:0];
    mask    = '1;
    sign    = 1'b0;
    case (size)
      4'd1: begin mask = XLEN'(8'hFF);         sign = raw[7];  end
      4'd2: begin mask = XLEN'(16'hFFFF);      sign = raw[15]; end
      4'd4: begin mask = XLEN'(32'hFFFF_FFFF); sign = raw[31]; end
      default: begin mask = '1;                sign = 1'b0;    end
    endcase
    data = (raw & mask) | ({XLEN{sign & ~unsigned_ld}} & ~mask);
  end
endmodule

// File: rtl/ama_riscv_load_align_unit.sv
// rtl/ama_riscv_load_align_unit.sv - load FSM: decode, one or two DMEM reads, extract and extend
module ama_riscv_load_align_unit
  import ama_riscv_load_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  ama_riscv_load_align_unit_if.slave       bus,
  output logic                             dmem_en,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0] dmem_addr,
  input  logic [XLEN-1:0]                  dmem_rdata
);
  localparam int OFF_W  = $clog2(XLEN/8);
  localparam int WORD_W = ADDR_W - OFF_W;

  logic [2:0]        state_q;
  logic [OFF_W-1:0]  off_q;
  logic [3:0]        size_q;
  logic              uns_q;
  logic              split_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   ext_data;
  logic [2*XLEN-1:0] window;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic [4:0]        req_end;
  logic              req_split;
  logic              req_mis;
  logic              req_err;

  assign req_off   = bus.req_addr[OFF_W-1:0];
  assign req_size  = load_size(bus.req_funct3);
  assign req_end   = 5'(req_off) + 5'(req_size);
  assign req_split = req_end > 5'(XLEN/8);
  assign req_mis   = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
  assign req_err   = !load_legal(bus.req_funct3, XLEN) || ((MISALIGN_EN == 0) && req_mis);

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dmem_en       = (state_q == ST_RD0) || (state_q == ST_RD1);

  // Non-split loads sit in the low half, so off alone selects the bytes either way.
  assign window = split_q ? {dmem_rdata, lo_q} : {{XLEN{1'b0}}, dmem_rdata};

  ama_riscv_load_extract #(.XLEN(XLEN)) u_extract (
    .window      (window),
    .off         (off_q),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .data        (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      lo_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      dmem_addr  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            off_q   <= req_off;
            size_q  <= req_size;
            uns_q   <= bus.req_funct3[2];
            split_q <= req_split;
            if (req_err) begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
              state_q    <= ST_RESP;
            end else begin
              dmem_addr <= bus.req_addr[ADDR_W-1:OFF_W];
              state_q   <= ST_RD0;
            end
          end
        end
        ST_RD0: begin
          if (split_q) begin
            dmem_addr <= dmem_addr + WORD_W'(1);
            state_q   <= ST_RD1;
          end else begin
            state_q <= ST_CAP;
          end
        end
        // First word of a split load arrives while the second is being read.
        ST_RD1: begin
          lo_q    <= dmem_rdata;
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          rsp_data_q <= ext_data;
          rsp_err_q  <= 1'b0;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ama_riscv_load_align_unit.md
Name: ama_riscv_load_align_unit

Overview:
Parametrised load datapath between the LSU request stage and DMEM. It supports RV32/RV64 byte, half, word and double loads with sign or zero extension. When enabled, misaligned loads that cross a DMEM word boundary are split into two word reads and the result is reassembled. Request and response use valid/ready handshakes; the response holds its value under backpressure and after the handshake.

Parameters:
XLEN, 32, data and DMEM word width in bits; legal values are 32 and 64.
ADDR_W, 32, byte address width.
MISALIGN_EN, 1, 1 = split boundary-crossing loads across two reads; 0 = flag all misaligned loads as an error.

Ports:
clk  in  1  clock, all flops on the rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  load request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  ADDR_W  byte address
req_funct3  in  3  RISC-V load funct3
dmem_en  out  1  DMEM read strobe; read data is returned exactly 1 cycle later
dmem_addr  out  ADDR_W-log2(XLEN/8)  DMEM word address
dmem_rdata  in  XLEN  DMEM read data
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_data  out  XLEN  extended load result
rsp_err  out  1  misaligned (with MISALIGN_EN=0) or illegal funct3

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. rsp_valid=0, rsp_err=0, rsp_data=0, dmem_en=0, dmem_addr=0, req_ready=1.
- Reset mid-operation: any in-flight access is abandoned. dmem_en drops in the same cycle. No response is produced for the abandoned load.
- Request decode:
  - size = 1/2/4/8 bytes from funct3[1:0].
  - funct3[2]=1 selects zero extension.
  - Illegal funct3: 111; 011 and 110 when XLEN=32.
  - off = req_addr[log2(XLEN/8)-1:0].
  - split = (off + size > XLEN/8).
  - misaligned = (off mod size != 0).
- Request fields are captured on the accept edge (req_valid && req_ready).
- States:
  - IDLE: req_ready=1. On accept:
    - illegal funct3, or (MISALIGN_EN=0 and misaligned): load rsp_err=1, rsp_data=0, go to RESP. No DMEM access is made.
    - otherwise go to RD0.
  - RD0: dmem_en=1, dmem_addr=word(addr). Next state is RD1 if split, else CAP.
  - RD1: dmem_en=1, dmem_addr=word(addr)+1, wrapping modulo 2^(ADDR_W-log2(XLEN/8)). Capture dmem_rdata into lo_q. Next state CAP.
  - CAP: form window = split ? {dmem_rdata, lo_q} : {0, dmem_rdata}. Extract size bytes starting at byte off, then sign- or zero-extend to XLEN. Register into rsp_data with rsp_err=0. Next state RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_err are stable while rsp_ready=0. On rsp_ready, go to IDLE.
- Latency (accept edge to rsp_valid high):
  - 3 cycles non-split.
  - 4 cycles split.
  - 1 cycle error.
  - No request pipelining: the next accept comes no earlier than the cycle after the response handshake.
- rsp_data and rsp_err hold their last values outside RESP. They update only in CAP or on an error accept.
- dmem_addr holds its last value when dmem_en=0.
- LD is legal only at XLEN=64. LW at XLEN=32 copies the full word.

Decomposition:
- Package ama_riscv_load_pkg:
  - funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU);
  - FSM state enum (IDLE, RD0, RD1, CAP, RESP);
  - size-decode and legality functions parametrised on XLEN.
- One combinational sub-module, ama_riscv_load_extract: window of 2*XLEN, off, size and unsigned flag in; extended XLEN result out. Bench it standalone as well.

Test Plan:
All values use XLEN=32 unless noted. dmem_addr values are word addresses.
1. Non-split byte load: word@0x40 = 0x80AA_55FF. LB at 0x103 gives 0xFFFF_FF80; LBU gives 0x0000_0080. One dmem_en pulse with dmem_addr=0x40. rsp_valid rises 3 cycles after accept.
2. Half load: LH at 0x102 with word = 0x1234_5678 gives 0x0000_1234. LH at 0x100 with word = 0x0000_8001 gives 0xFFFF_8001.
3. Split word, MISALIGN_EN=1: word@0x40 = 0x4433_2211, word@0x41 = 0x8877_6655. LW at 0x101 gives 0x5544_3322. dmem_addr is 0x40 then 0x41 on consecutive cycles. rsp_valid rises 4 cycles after accept.
4. Split half and wrap, ADDR_W=12: LH at 0x103 using the words from scenario 3 gives 0x0000_5544. LW at 0xFFE reads word 0x3FF then word 0x000.
5. Error path:
   - MISALIGN_EN=0, LW at 0x102: rsp_err=1, rsp_data=0, dmem_en never asserted, 1-cycle latency.
   - XLEN=32, funct3=011: rsp_err=1.
   - XLEN=64, LD at 0x8 with word=0x8000_0000_0000_0001: rsp_data=0x8000_0000_0000_0001, rsp_err=0.
6. Backpressure and reset:
   - Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid, rsp_data and rsp_err stay stable; req_ready=0.
   - Pull rst_n low while in RD1: dmem_en=0 and rsp_valid=0 immediately. req_ready=1 after release, and a fresh LW at 0x0 completes normally.
